// File: rtl/aes_sbox_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox_pipe
//  Description : Pipelined multi-lane AES byte substitution (forward S-box,
//                optional inverse S-box) with a valid/ready stream interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox_pipe #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter int INV_EN      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_inv,
    output logic                 busy
);

    localparam int c_W = 8 * LANES;

    // ------------------------------------------------------------------
    // GF(2^8) helpers used only to fill the constant lookup tables; every
    // table entry is a constant index, so these fold away at elaboration.
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires)
    function automatic logic [7:0] f_ginv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = f_gmul(r, r);
            if (i != 0) r = f_gmul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] f_rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] f_sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = f_ginv(x);
        return y ^ f_rotl(y, 1) ^ f_rotl(y, 2) ^ f_rotl(y, 3) ^ f_rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] f_sbox_inv(input logic [7:0] s);
        logic [7:0] t;
        t = f_rotl(s, 1) ^ f_rotl(s, 3) ^ f_rotl(s, 6) ^ 8'h05;
        return f_ginv(t);
    endfunction

    // ------------------------------------------------------------------
    // Lookup tables and per-lane substitution (combinational, feeds stage 1)
    // ------------------------------------------------------------------
    logic [7:0]     w_fwd_tab [256];
    logic [c_W-1:0] w_sub;

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_fwd_tab
            assign w_fwd_tab[gi] = f_sbox_fwd(8'(gi));
        end

        if (INV_EN != 0) begin : g_inv_en
            logic [7:0] w_inv_tab [256];
            for (gi = 0; gi < 256; gi++) begin : g_inv_tab
                assign w_inv_tab[gi] = f_sbox_inv(8'(gi));
            end
            // One mode bit selects the table for every lane of the word
            for (gi = 0; gi < LANES; gi++) begin : g_lane
                assign w_sub[8*gi +: 8] = in_inv ? w_inv_tab[in_data[8*gi +: 8]]
                                                 : w_fwd_tab[in_data[8*gi +: 8]];
            end
        end else begin : g_fwd_only
            for (gi = 0; gi < LANES; gi++) begin : g_lane
                assign w_sub[8*gi +: 8] = w_fwd_tab[in_data[8*gi +: 8]];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline registers and flow control
    // ------------------------------------------------------------------
    logic [PIPE_STAGES-1:0] r_valid;
    logic [c_W-1:0]         r_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] r_inv;

    logic [PIPE_STAGES-1:0] w_ready;
    logic [PIPE_STAGES-1:0] w_src_valid;
    logic [c_W-1:0]         w_src_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] w_src_inv;

    generate
        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage_ctl
            // A stage may load unless it and every stage after it are full
            // while the output is stalled (unrolled ready chain).
            assign w_ready[gi] = out_ready | ~(&r_valid[PIPE_STAGES-1:gi]);

            if (gi == 0) begin : g_src_in
                assign w_src_valid[gi] = in_valid;
                assign w_src_data[gi]  = w_sub;
                assign w_src_inv[gi]   = in_inv;
            end else begin : g_src_prev
                assign w_src_valid[gi] = r_valid[gi-1];
                assign w_src_data[gi]  = r_data[gi-1];
                assign w_src_inv[gi]   = r_inv[gi-1];
            end
        end
    endgenerate

    // Advance each stage that is free to load; payload only captured with a valid word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_inv   <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_data[k] <= w_src_data[k];
                        r_inv[k]  <= w_src_inv[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[PIPE_STAGES-1];
    assign out_data  = r_data[PIPE_STAGES-1];
    assign out_inv   = r_inv[PIPE_STAGES-1];
    assign busy      = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_sbox_pipe
//  Description : Scoreboard bench for aes_sbox_pipe (4 lanes / 2 stages with
//                inverse, plus a forward-only 1-stage instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_pipe;

    localparam logic [7:0] c_sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef struct packed {
        logic        inv;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_inv;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_inv, busy;
    logic [31:0] out_data;

    logic        f_in_valid, f_in_ready, f_in_inv;
    logic [31:0] f_in_data;
    logic        f_out_valid, f_out_inv, f_busy;
    logic [31:0] f_out_data;

    logic [7:0]  isbox [256];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          rand_rdy = 1'b0;

    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_inv;

    always #5 clk = ~clk;

    aes_sbox_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv),
        .busy(busy)
    );

    aes_sbox_pipe #(.LANES(4), .PIPE_STAGES(1), .INV_EN(0)) u_fwd (
        .clk(clk), .rst(rst),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data), .in_inv(f_in_inv),
        .out_valid(f_out_valid), .out_ready(1'b1), .out_data(f_out_data), .out_inv(f_out_inv),
        .busy(f_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_exp(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = inv ? isbox[d[8*i +: 8]] : c_sbox[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] f_word(input int v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((v + 67 * i) & 255);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Hold a word on the input until accepted, logging its expected result
    task automatic send(input logic [31:0] d, input logic inv, input logic [31:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{inv: inv, data: exp});
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("send_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
            tick();
        end
        chk("drain_empty", sb.size(), 32'd0);
        tick();
    endtask

    // Output monitor: pops the scoreboard on each output transfer, checks hold while stalled
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", out_data, prev_data);
                chk("hold_inv", {31'd0, out_inv}, {31'd0, prev_inv});
            end
            if (out_valid && out_ready) begin
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_out: observed %h expected none", out_data);
                end
                if (sb.size() != 0) begin
                    chk("out_data", out_data, sb[0].data);
                    chk("out_inv", {31'd0, out_inv}, {31'd0, sb[0].inv});
                    void'(sb.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_inv   = out_inv;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) isbox[c_sbox[i]] = 8'(i);
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
        f_in_valid = 1'b0; f_in_data = '0; f_in_inv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_inv", {31'd0, out_inv}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_f_out_data", f_out_data, 32'd0);
        tick();

        // Forward lookup with two-stage latency
        in_valid = 1'b1; in_data = 32'hFF530100; in_inv = 1'b0;
        @(negedge clk);
        chk("fwd_in_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back('{inv: 1'b0, data: f_exp(32'hFF530100, 1'b0)});
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        tick();
        @(negedge clk);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("fwd_literal", out_data, 32'h16ED7C63);
        tick();

        // Back-to-back inverse then forward on the same bytes
        send(32'h16ED7C63, 1'b1, f_exp(32'h16ED7C63, 1'b1));
        send(32'h16ED7C63, 1'b0, f_exp(32'h16ED7C63, 1'b0));
        @(negedge clk);
        chk("inv_literal", out_data, 32'hFF530100);
        chk("inv_flag", {31'd0, out_inv}, 32'd1);
        tick();
        @(negedge clk);
        chk("mode_switch_literal", out_data, 32'h475510FB);
        chk("mode_switch_flag", {31'd0, out_inv}, 32'd0);
        tick();
        drain();

        // Backpressure: only two words fit while the output is stalled
        out_ready = 1'b0;
        send(32'h00112233, 1'b0, f_exp(32'h00112233, 1'b0));
        send(32'h44556677, 1'b1, f_exp(32'h44556677, 1'b1));
        in_valid = 1'b1; in_data = 32'h8899AABB; in_inv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_in_ready", {31'd0, in_ready}, 32'd0);
            chk("full_out_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pass_through", {31'd0, in_ready}, 32'd1);
        sb.push_back('{inv: 1'b0, data: f_exp(32'h8899AABB, 1'b0)});
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("release_stream", {31'd0, out_valid}, 32'd1);
            tick();
        end
        drain();

        // Reset with words in flight (and a simultaneous handshake attempt)
        out_ready = 1'b0;
        send(32'hDEADBEEF, 1'b0, f_exp(32'hDEADBEEF, 1'b0));
        send(32'h01234567, 1'b1, f_exp(32'h01234567, 1'b1));
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hCAFEF00D;
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        repeat (5) tick();

        // Forward-only build ignores the inverse request
        f_in_valid = 1'b1; f_in_data = 32'h00000000; f_in_inv = 1'b1;
        @(negedge clk);
        chk("f_in_ready", {31'd0, f_in_ready}, 32'd1);
        tick();
        f_in_data = 32'hFF530100;
        @(negedge clk);
        chk("f_valid_1stage", {31'd0, f_out_valid}, 32'd1);
        chk("f_zero_word", f_out_data, 32'h63636363);
        tick();
        f_in_valid = 1'b0;
        @(negedge clk);
        chk("f_second_word", f_out_data, 32'h16ED7C63);
        tick();

        // Sweep every byte value per lane forward, then back through the inverse
        rand_rdy = 1'b1;
        for (int v = 0; v < 256; v++) begin
            repeat ($urandom_range(0, 1)) tick();
            send(f_word(v), 1'b0, f_exp(f_word(v), 1'b0));
        end
        for (int v = 0; v < 256; v++) begin
            repeat ($urandom_range(0, 1)) tick();
            send(f_exp(f_word(v), 1'b0), 1'b1, f_word(v));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
